// File: rtl/remote_cmd_responder.sv
// MazeRunner end of the Bluetooth command link: 8N1 UART receiver that pairs bytes
// into 16-bit commands, plus a one-byte response transmitter. RX and TX are independent.
module remote_cmd_responder #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_HALF   = 12'(BAUD_DIV / 2);
  localparam logic [17:0] TMO_LAST    = 18'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    AS_HIGH = 1'b0,
    AS_LOW  = 1'b1
  } as_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_XMIT = 1'b1
  } tx_state_e;

  rx_state_e   rx_state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic [11:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [8:0]  rx_sh_q;
  logic        frm_err_q;

  as_state_e   as_state_q;
  logic [7:0]  high_q;
  logic [17:0] tmo_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;

  tx_state_e   tx_state_q;
  logic [9:0]  tx_sh_q;
  logic [11:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_busy_q;
  logic        resp_sent_q;

  logic        byte_done;
  logic        frm_det;
  logic        start_ok;
  logic [7:0]  rx_byte;

  // The shifter carries the start bit down to bit 0, so a good frame is start=0 and stop=1.
  assign rx_byte = rx_sh_q[8:1];

  // Receiver events, decoded in the cycle the deciding sample is taken.
  always_comb begin
    byte_done = 1'b0;
    frm_det   = 1'b0;
    start_ok  = 1'b0;
    if (rx_cnt_q == 12'd0) begin
      case (rx_state_q)
        RX_START: start_ok = ~rx_sync_q;
        RX_STOP: begin
          byte_done = rx_sync_q & ~rx_sh_q[0];
          frm_det   = ~rx_sync_q;
        end
        default: begin
          byte_done = 1'b0;
          frm_det   = 1'b0;
          start_ok  = 1'b0;
        end
      endcase
    end else begin
      byte_done = 1'b0;
      frm_det   = 1'b0;
      start_ok  = 1'b0;
    end
  end

  // UART receiver: synchronizer, start-bit qualification and bit sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 12'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 9'd0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      frm_err_q <= frm_det;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= BAUD_HALF;
          end
        end
        RX_START: begin
          if (rx_cnt_q != 12'd0) begin
            rx_cnt_q <= rx_cnt_q - 12'd1;
          end else if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= BAUD_RELOAD;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= {rx_sync_q, 8'h00};
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != 12'd0) begin
            rx_cnt_q <= rx_cnt_q - 12'd1;
          end else begin
            rx_sh_q  <= {rx_sync_q, rx_sh_q[8:1]};
            rx_cnt_q <= BAUD_RELOAD;
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != 12'd0) begin
            rx_cnt_q <= rx_cnt_q - 12'd1;
          end else begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Byte pairing with partial-command timeout, and the cmd/cmd_rdy handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      as_state_q <= AS_HIGH;
      high_q     <= 8'd0;
      tmo_q      <= 18'd0;
      cmd_q      <= 16'd0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      case (as_state_q)
        AS_HIGH: begin
          if (byte_done) begin
            high_q     <= rx_byte;
            tmo_q      <= 18'd0;
            as_state_q <= AS_LOW;
          end
        end
        AS_LOW: begin
          if (byte_done) begin
            cmd_q      <= {high_q, rx_byte};
            as_state_q <= AS_HIGH;
          end else if (frm_det || (tmo_q >= TMO_LAST)) begin
            high_q     <= 8'd0;
            as_state_q <= AS_HIGH;
          end else if (tmo_q != 18'h3FFFF) begin
            tmo_q <= tmo_q + 18'd1;
          end
        end
        default: as_state_q <= AS_HIGH;
      endcase

      // A completed command beats a simultaneous acknowledge.
      if ((as_state_q == AS_LOW) && byte_done) begin
        cmd_rdy_q <= 1'b1;
      end else if (clr_cmd_rdy || ((as_state_q == AS_HIGH) && start_ok)) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  // Response transmitter; TX is bit 0 of the shifter, which idles at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_sh_q     <= 10'h3FF;
      tx_cnt_q    <= 12'd0;
      tx_bit_q    <= 4'd0;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (send_resp) begin
            tx_sh_q    <= {1'b1, resp, 1'b0};
            tx_cnt_q   <= BAUD_RELOAD;
            tx_bit_q   <= 4'd0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt_q != 12'd0) begin
            tx_cnt_q <= tx_cnt_q - 12'd1;
          end else begin
            tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
            tx_cnt_q <= BAUD_RELOAD;
            tx_bit_q <= tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd9) begin
              tx_state_q  <= TX_IDLE;
              tx_busy_q   <= 1'b0;
              resp_sent_q <= 1'b1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign TX        = tx_sh_q[0];
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;
  assign tx_busy   = tx_busy_q;
  assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_remote_cmd_responder.sv
// Scoreboard bench for remote_cmd_responder: stimulus pushes expected commands and
// response bytes; a negedge monitor decodes cmd_rdy rises and TX frames and compares.
module tb_remote_cmd_responder;

  localparam int BD  = 8;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  remote_cmd_responder #(.BAUD_DIV(BD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;
  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor state
  logic       prev_rdy = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_frm = 1'b0;
  logic       skip_fall = 1'b0;
  logic       tx_act = 1'b0;
  int         tx_cyc = 0;
  int         busy_len = 0;
  logic [9:0] tx_bits = 10'h000;

  always @(negedge clk) begin
    if (rst) begin
      tx_act = 1'b0;
      if (tx_busy) skip_fall = 1'b1;
    end else begin
      if (cmd_rdy && !prev_rdy) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd_rdy actual cmd=%0h required none", cmd);
        end else begin
          chk("cmd", cmd, exp_cmd_q.pop_front());
        end
      end
      if (frm_err) begin
        frm_cnt++;
        if (prev_frm) begin
          checks++; errors++;
          $display("FAIL frm_err_width actual=2+ cycles required=1");
        end
      end
      if (tx_busy) busy_len++;
      if (prev_busy && !tx_busy) begin
        if (skip_fall) begin
          skip_fall = 1'b0;
        end else begin
          chk("tx_busy_len", busy_len, 80);
          chk("resp_sent_at_end", resp_sent, 1);
        end
        busy_len = 0;
      end else if (resp_sent) begin
        checks++; errors++;
        $display("FAIL stray_resp_sent actual=1 required=0");
      end
      if (!tx_act && TX == 1'b0) begin
        tx_act = 1'b1;
        tx_cyc = 0;
      end
      if (tx_act) begin
        if (tx_cyc % 8 == 4) tx_bits[tx_cyc / 8] = TX;
        if (tx_cyc == 76) begin
          tx_act = 1'b0;
          chk("tx_start_bit", tx_bits[0], 0);
          chk("tx_stop_bit", tx_bits[9], 1);
          if (exp_tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx_frame actual=%0h required none", tx_bits[8:1]);
          end else begin
            chk("tx_data", tx_bits[8:1], exp_tx_q.pop_front());
          end
        end
        tx_cyc++;
      end
    end
    prev_rdy  = cmd_rdy;
    prev_busy = tx_busy;
    prev_frm  = frm_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    wait_cyc(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cyc(BD);
    end
    RX = stop;
    wait_cyc(BD);
    RX = 1'b1;
    wait_cyc(2 * BD);
  endtask

  task automatic pulse_send(input logic [7:0] r);
    resp = r;
    send_resp = 1'b1;
    wait_cyc(1);
    send_resp = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_cmd_q.size() != 0 || exp_tx_q.size() != 0) && n < budget) begin
      wait_cyc(1);
      n++;
    end
    if (exp_cmd_q.size() != 0 || exp_tx_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual pending=%0d required 0", name,
               exp_cmd_q.size() + exp_tx_q.size());
      exp_cmd_q.delete();
      exp_tx_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    chk("rst_TX", TX, 1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_resp_sent", resp_sent, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_frm_err", frm_err, 0);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(4);

    // 1: basic command, then acknowledge
    exp_cmd_q.push_back(16'h23FF);
    send_byte(8'h23, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_drain("cmd_23ff", 200);
    clr_cmd_rdy = 1'b1;
    wait_cyc(1);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("clr_cmd_rdy", cmd_rdy, 0);
    chk("cmd_hold_after_clr", cmd, 16'h23FF);

    // 2: response byte, with a request mid-frame that must be ignored
    wait_cyc(2);
    exp_tx_q.push_back(8'hA5);
    pulse_send(8'hA5);
    chk("tx_start_latency", TX, 0);
    chk("tx_busy_set", tx_busy, 1);
    resp = 8'h3C;
    wait_cyc(18);
    pulse_send(8'h3C);
    wait_drain("tx_a5", 200);
    wait_cyc(100);

    // 3: partial command timeout
    send_byte(8'h40, 1'b1);
    wait_cyc(250);
    @(negedge clk);
    chk("no_rdy_after_timeout", cmd_rdy, 0);
    chk("cmd_hold_timeout", cmd, 16'h23FF);
    exp_cmd_q.push_back(16'h6000);
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("cmd_6000", 200);

    // 4: framing error with no high byte, then a clean command
    send_byte(8'h12, 1'b0);
    wait_cyc(20);
    chk("frm_err_count_1", frm_cnt, 1);
    exp_cmd_q.push_back(16'h0000);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("cmd_0000", 200);

    // 4b: framing error on the low byte drops the pending high byte
    send_byte(8'h77, 1'b1);
    send_byte(8'h99, 1'b0);
    wait_cyc(20);
    chk("frm_err_count_2", frm_cnt, 2);
    exp_cmd_q.push_back(16'hABCD);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_drain("cmd_abcd", 200);

    // 5: short low glitch is rejected and does not disturb cmd_rdy
    RX = 1'b0;
    wait_cyc(3);
    RX = 1'b1;
    wait_cyc(30);
    chk("glitch_no_frm_err", frm_cnt, 2);
    chk("glitch_keeps_rdy", cmd_rdy, 1);
    chk("glitch_keeps_cmd", cmd, 16'hABCD);
    exp_cmd_q.push_back(16'h5AC3);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_drain("cmd_5ac3", 200);

    // 6: reset in the middle of a TX frame and an RX frame
    pulse_send(8'h3C);
    RX = 1'b0;
    wait_cyc(BD);
    RX = 1'b1;
    wait_cyc(12);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_TX", TX, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    chk("midrst_cmd_rdy", cmd_rdy, 0);
    chk("midrst_cmd", cmd, 16'h0000);
    wait_cyc(4);
    exp_cmd_q.push_back(16'h2000);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_drain("cmd_2000", 200);
    exp_tx_q.push_back(8'h81);
    pulse_send(8'h81);
    wait_drain("tx_81", 200);
    wait_cyc(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/remote_cmd_responder.md
Name: remote_cmd_responder

Overview:
- MazeRunner-side end of the Bluetooth command link.
- Receives 8N1 UART bytes from the remote commander and assembles each high/low byte pair into one 16-bit command for the command processor, raising cmd_rdy.
- Transmits the single response byte back (0xA5 pos-ack, or others) on request.
- Contains its own UART receiver and transmitter.

Parameters:
BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud); legal range 4..4095.
TIMEOUT_CYC, 131072, idle clk cycles after a high byte before the partial command is discarded.

Ports:
clk  in  1  system clock
rst  in  1  one clock; reset is synchronous and active-high
RX  in  1  serial in from remote (asynchronous, idle high)
TX  out  1  serial out to remote (idle high)
cmd  out  16  assembled command, high byte = first byte received
cmd_rdy  out  1  full 16-bit command valid
clr_cmd_rdy  in  1  consumer acknowledge, clears cmd_rdy
resp  in  8  response byte to send
send_resp  in  1  one-cycle request to transmit resp
resp_sent  out  1  one-cycle pulse when stop bit of resp completes
tx_busy  out  1  transmitter active
frm_err  out  1  one-cycle pulse on framing error (stop bit sampled 0)

Behaviour:
Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0. RX synchronizer flops preset to 1. All FSMs go to IDLE/HIGH_WAIT. Reset mid-frame aborts both RX and TX immediately.

RX path:
- RX passes through a 2-flop synchronizer before use.
- IDLE: on synced RX = 0, go to START and load baud counter with BAUD_DIV/2.
- START: when counter expires, resample. If RX = 1, it was a glitch; go to IDLE. Otherwise go to DATA.
- DATA: sample every BAUD_DIV cycles, 8 bits, LSB first, shifted into a 9-bit shifter.
- STOP: sample the stop bit.
  - Stop = 1: byte_done pulse.
  - Stop = 0: frm_err pulse, no byte_done, byte discarded.
- Return to IDLE in both cases.

Byte assembly FSM (HIGH_WAIT, LOW_WAIT):
- HIGH_WAIT + byte_done: store byte in high register, clear timeout counter, go to LOW_WAIT.
- LOW_WAIT + byte_done: cmd <= {high, byte}, cmd_rdy <= 1 in the same cycle, go to HIGH_WAIT.
- LOW_WAIT timeout counter counts every cycle; at TIMEOUT_CYC, discard the high byte and go to HIGH_WAIT (cmd and cmd_rdy untouched).
- frm_err in LOW_WAIT: discard the high byte, go to HIGH_WAIT.

cmd / cmd_rdy rules:
- cmd changes only when cmd_rdy is set; it is stable otherwise.
- cmd_rdy clears on clr_cmd_rdy, or when a start bit is accepted in HIGH_WAIT, i.e. a new command is beginning.
- If set and clear occur in the same cycle, set wins.

TX path (IDLE, XMIT):
- IDLE: on send_resp, latch {1, resp, 0} into a 10-bit shifter, tx_busy <= 1, go to XMIT.
- XMIT: TX = shifter LSB; shift every BAUD_DIV cycles. After 10 bit times, go to IDLE, tx_busy <= 0, resp_sent pulses 1 cycle.
- TX is registered; it is 0 (start bit) the cycle after send_resp is accepted.
- send_resp while tx_busy = 1 is ignored; resp is not re-latched.
- A new send_resp is accepted in the same cycle resp_sent pulses.
- RX and TX run fully independently (full duplex).

Arithmetic:
- Baud counters are 12 bits, count down to 0.
- Timeout counter is 18 bits and saturates.

Test Plan (BAUD_DIV=8, TIMEOUT_CYC=200 in sim):
1. Serialize 0x23 then 0xFF on RX with 8-cycle bits -> cmd_rdy rises 1 cycle after sync-delayed stop-bit sample of the 2nd byte, cmd=0x23FF; pulse clr_cmd_rdy -> cmd_rdy=0, cmd holds 0x23FF.
2. send_resp with resp=0xA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 with each bit lasting 8 cycles, tx_busy high 80 cycles, resp_sent single pulse at end; a second send_resp at cycle 20 is ignored.
3. Send 0x40, idle 250 cycles, then 0x60, 0x00 -> no cmd_rdy after 0x40; cmd=0x6000 with cmd_rdy=1 after the third byte.
4. Byte 0x12 with stop bit forced 0 -> frm_err pulses once, no byte accepted; following 0x00, 0x00 -> cmd=0x0000, cmd_rdy=1.
5. 3-cycle low glitch on RX in IDLE -> no byte_done, no frm_err, FSM back to IDLE.
6. Assert rst mid-TX and mid-RX -> TX=1, tx_busy=0, cmd_rdy=0, cmd=0 next cycle; clean 0x2000 afterwards is received correctly.
